button_conditioner: RTL and testbench

- Front-end stage directly upstream of the game top level: takes the seven raw board push-buttons (a, b, up, down, left, right, start) and produces clean per-button signals for the top's button inputs.
- Each button goes through a 2-FF synchroniser, a debouncer and a press-event generator.
- Press events are stretched so the slow game clock (system clock / 8 Hz divider) always samples them. Direction buttons auto-repeat while held.

---
 rtl/button_conditioner.sv | 151 +++++++++++++++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions the seven raw board push-buttons into clean debounced levels and
// stretched press/auto-repeat events sized for the slow game clock.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned PULSE_CYCLES    = 6_250_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 12_500_000,
    parameter logic [6:0]  REPEAT_MASK     = 7'b0111100,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] raw_buttons,
    output logic [6:0] btn_level,
    output logic [6:0] btn_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST_WAIT,
        REPEAT_WAIT
    } rep_state_t;

    localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
    localparam logic [31:0] PULSE_LEN   = 32'(PULSE_CYCLES);
    localparam logic [6:0]  RELEASED    = {7{RAW_ACTIVE_LOW}};

    logic [6:0] sync_meta;
    logic [6:0] sync_out;
    logic [6:0] sync_sample;

    // Reset loads the released level so no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= RELEASED;
            sync_out  <= RELEASED;
        end else begin
            sync_meta <= raw_buttons;
            sync_out  <= sync_meta;
        end
    end

    assign sync_sample = sync_out ^ RELEASED;

    for (genvar i = 0; i < 7; i++) begin : g_bit
        logic [31:0] deb_cnt;
        logic [31:0] rep_cnt;
        logic [31:0] rep_cnt_next;
        logic [31:0] pulse_cnt;
        logic        level_q;
        logic        differ;
        logic        toggle;
        logic        rise;
        logic        fall;
        logic        event_fire;
        rep_state_t  state;
        rep_state_t  state_next;

        assign differ = sync_sample[i] != level_q;
        assign toggle = differ && (deb_cnt == DEB_LAST);
        assign rise   = toggle && !level_q;
        assign fall   = toggle && level_q;

        always_ff @(posedge clk) begin
            if (!reset) begin
                deb_cnt <= '0;
                level_q <= 1'b0;
            end else if (!differ) begin
                deb_cnt <= '0;
            end else if (toggle) begin
                deb_cnt <= '0;
                level_q <= ~level_q;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end

        // The FSM reacts to the upcoming level change so the first event lines
        // up with the level rise; a masked button parks at the end of its delay.
        always_comb begin
            state_next   = state;
            rep_cnt_next = rep_cnt;
            event_fire   = 1'b0;
            case (state)
                IDLE: begin
                    rep_cnt_next = '0;
                    if (rise) begin
                        state_next = FIRST_WAIT;
                        event_fire = 1'b1;
                    end
                end
                FIRST_WAIT: begin
                    if (fall) begin
                        state_next   = IDLE;
                        rep_cnt_next = '0;
                    end else if (rep_cnt == DELAY_LAST) begin
                        if (REPEAT_MASK[i]) begin
                            state_next   = REPEAT_WAIT;
                            rep_cnt_next = '0;
                            event_fire   = 1'b1;
                        end
                    end else begin
                        rep_cnt_next = rep_cnt + 32'd1;
                    end
                end
                REPEAT_WAIT: begin
                    if (fall) begin
                        state_next   = IDLE;
                        rep_cnt_next = '0;
                    end else if (rep_cnt == PERIOD_LAST) begin
                        rep_cnt_next = '0;
                        event_fire   = 1'b1;
                    end else begin
                        rep_cnt_next = rep_cnt + 32'd1;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                state   <= IDLE;
                rep_cnt <= '0;
            end else begin
                state   <= state_next;
                rep_cnt <= rep_cnt_next;
            end
        end

        // A new event simply reloads the stretcher, so back-to-back events merge.
        always_ff @(posedge clk) begin
            if (!reset) begin
                pulse_cnt <= '0;
            end else if (event_fire) begin
                pulse_cnt <= PULSE_LEN;
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 32'd1;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_cnt != '0;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// key activity, scored against a sliding-window / event-time reference model.
module tb_button_conditioner;

    localparam int         DEB  = 4;
    localparam int         PUL  = 3;
    localparam int         RDLY = 20;
    localparam int         RPER = 8;
    localparam logic [6:0] MASK = 7'b0111100;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] raw_buttons;
    logic [6:0] btn_level;
    logic [6:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];

    logic [6:0] m_pipe[$];
    logic [6:0] m_hist[$];
    logic [6:0] m_level;
    int         m_cycle = 0;
    int         m_rise_t[7];
    int         m_last_evt[7];

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES(PUL),
        .REPEAT_DELAY(RDLY),
        .REPEAT_PERIOD(RPER),
        .REPEAT_MASK(MASK),
        .RAW_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_buttons(raw_buttons),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    // Reference: level follows the last DEB synchronised samples when they all
    // disagree with it; events are placed by arithmetic on the time since rise.
    task automatic model_step(input logic rst_n, input logic [6:0] raw);
        logic [6:0] sample;
        logic [6:0] pulse;
        logic [6:0] old_level;
        logic       all_flip;
        int         since;
        m_cycle++;
        pulse = '0;
        if (!rst_n) begin
            m_level = '0;
            m_pipe  = '{7'h00, 7'h00};
            m_hist.delete();
            for (int i = 0; i < 7; i++) m_last_evt[i] = -1000;
        end else begin
            sample = m_pipe.pop_front();
            m_pipe.push_back(~raw);
            m_hist.push_back(sample);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            old_level = m_level;
            for (int i = 0; i < 7; i++) begin
                if (m_hist.size() == DEB) begin
                    all_flip = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (m_hist[j][i] == m_level[i]) all_flip = 1'b0;
                    if (all_flip) m_level[i] = ~m_level[i];
                end
                if (m_level[i]) begin
                    if (!old_level[i]) m_rise_t[i] = m_cycle;
                    since = m_cycle - m_rise_t[i];
                    if (since == 0 || (MASK[i] && since >= RDLY && (since - RDLY) % RPER == 0))
                        m_last_evt[i] = m_cycle;
                end
                pulse[i] = (m_cycle - m_last_evt[i]) < PUL;
            end
        end
        exp_q.push_back({m_level, pulse});
    endtask

    task automatic applyStimulus(input logic rst_n, input logic [6:0] raw);
        reset       = rst_n;
        raw_buttons = raw;
        model_step(rst_n, raw);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Directed expectation: events at rise, rise+RDLY, then every RPER (if
    // repeating), only while level is still high, each PUL cycles wide.
    function automatic logic exp_pulse(input int k, input int rise, input int fall, input bit rep);
        int t;
        t = rise;
        while (t < fall) begin
            if (k >= t && k < t + PUL) return 1'b1;
            if (!rep) break;
            t = (t == rise) ? rise + RDLY : t + RPER;
        end
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 7'h7F);
    endtask

    initial begin : monitor
        logic [13:0] e;
        int          edge_no;
        edge_no = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                edge_no++;
                e = exp_q.pop_front();
                checks++;
                if (btn_level !== e[13:7]) begin
                    errors++;
                    $display("[TB] FAIL sb_level edge %0d: got %b expected %b", edge_no, btn_level, e[13:7]);
                end
                checks++;
                if (btn_pulse !== e[6:0]) begin
                    errors++;
                    $display("[TB] FAIL sb_pulse edge %0d: got %b expected %b", edge_no, btn_pulse, e[6:0]);
                end
            end
        end
    end

    initial begin : stimulus
        logic [6:0] pressed;
        int         hold[7];
        logic       rst_n;

        // Reset with every key held, then release reset
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 7'h00);
            checkOutput("rst_level", btn_level, 7'h00);
            checkOutput("rst_pulse", btn_pulse, 7'h00);
        end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 7'h00);
            checkOutput("rel_level", btn_level, (k == 6) ? 7'h7F : 7'h00);
        end
        idle(40);

        $display("[TB] clean press of a");
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 7'h7E);
            checkOutput("a_level", 7'(btn_level[0]), 7'(k >= 6));
            checkOutput("a_pulse", 7'(btn_pulse[0]), 7'(exp_pulse(k, 6, 1000, 1'b0)));
        end
        idle(15);

        $display("[TB] glitch on up");
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(1'b1, (k <= 3) ? 7'h7B : 7'h7F);
            checkOutput("glitch_level", 7'(btn_level[2]), 7'h00);
            checkOutput("glitch_pulse", 7'(btn_pulse[2]), 7'h00);
        end

        $display("[TB] auto-repeat on up");
        for (int k = 1; k <= 62; k++) begin
            applyStimulus(1'b1, (k <= 50) ? 7'h7B : 7'h7F);
            checkOutput("rep_level", 7'(btn_level[2]), 7'(k >= 6 && k < 56));
            checkOutput("rep_pulse", 7'(btn_pulse[2]), 7'(exp_pulse(k, 6, 56, 1'b1)));
        end
        idle(10);

        $display("[TB] release mid-pulse on left");
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(1'b1, (k <= 7) ? 7'h6F : 7'h7F);
            checkOutput("mid_level", 7'(btn_level[4]), 7'(k >= 6 && k < 13));
            checkOutput("mid_pulse", 7'(btn_pulse[4]), 7'(exp_pulse(k, 6, 13, 1'b1)));
        end

        $display("[TB] simultaneous start and right");
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, (k <= 30) ? 7'h1F : 7'h7F);
            checkOutput("sim_level", 7'(btn_level[6:5]), (k >= 6 && k < 36) ? 7'h03 : 7'h00);
            checkOutput("sim_pulse", 7'(btn_pulse[6:5]),
                        7'({exp_pulse(k, 6, 36, 1'b0), exp_pulse(k, 6, 36, 1'b1)}));
        end
        idle(10);

        $display("[TB] random key activity");
        pressed = '0;
        for (int i = 0; i < 7; i++) hold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 7; i++) begin
                if (hold[i] == 0) begin
                    pressed[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 60));
                end
                hold[i]--;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus(rst_n, ~pressed);
        end

        for (int w = 0; w < 5 && exp_q.size() != 0; w++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
